// File: rtl/prog_counter.sv
// Programmable up/down counter/timer with prescaler, limit and three boundary
// modes (wrap, saturate, one-shot). Emits a one-cycle terminal-count pulse,
// a sticky wrap flag and RUN/DONE status flags. Every output is registered.
//
// Control protocol: there is no valid/ready handshake. clear, load and enable
// are level inputs sampled on every rising edge. Priority is Reset_n=0, then
// clear, then load, then counting. mode, up_down, limit and prescale are not
// latched; the values present at the edge of a tick decide that tick.
// running/done together expose the full FSM state for observation.
module prog_counter #(
    parameter int WIDTH = 32,
    parameter int PRE_W = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             up_down,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    input  logic [PRE_W-1:0] prescale,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrapped,
    output logic             running,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [PRE_W-1:0] pcnt_q, pcnt_d;
    logic             tc_q, tc_d;
    logic             wrapped_q, wrapped_d;

    logic             tick;
    logic             at_boundary;
    logic [WIDTH-1:0] count_step;
    logic [WIDTH-1:0] boundary_value;
    logic [WIDTH-1:0] wrap_value;

    // Next-state, prescaler and count update; defaults hold every register.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pcnt_d    = pcnt_q;
        tc_d      = 1'b0;
        wrapped_d = wrapped_q;

        // A tick only happens while running; the prescaler freezes otherwise.
        tick = (state_q == ST_RUN) && (pcnt_q == prescale);

        // Boundary test, one-step move and wrap target depend on direction.
        if (up_down) begin
            at_boundary    = (count_q >= limit);
            count_step     = count_q + WIDTH'(1);
            boundary_value = limit;
            wrap_value     = '0;
        end else begin
            at_boundary    = (count_q == '0);
            count_step     = count_q - WIDTH'(1);
            boundary_value = '0;
            wrap_value     = limit;
        end

        if (clear) begin
            state_d   = ST_IDLE;
            count_d   = '0;
            pcnt_d    = '0;
            wrapped_d = 1'b0;
        end else if (load) begin
            // Load keeps the state, except that it re-arms a finished one-shot.
            count_d = load_value;
            pcnt_d  = '0;
            if (state_q == ST_DONE) begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end
                    if (tick) begin
                        pcnt_d = '0;
                        if (!at_boundary) begin
                            count_d = count_step;
                            // Saturate pulses only on the step that lands on the boundary.
                            if (mode == MODE_SAT && count_step == boundary_value) begin
                                tc_d = 1'b1;
                            end
                        end else if (mode == MODE_SAT) begin
                            count_d = count_q;
                        end else if (mode == MODE_ONESHOT) begin
                            // Finishing wins over a simultaneous enable drop.
                            tc_d    = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            count_d   = wrap_value;
                            tc_d      = 1'b1;
                            wrapped_d = 1'b1;
                        end
                    end else begin
                        // Lowering prescale below pcnt lets this wrap around naturally.
                        pcnt_d = pcnt_q + PRE_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Register bank with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            pcnt_q    <= '0;
            tc_q      <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pcnt_q    <= pcnt_d;
            tc_q      <= tc_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign wrapped = wrapped_q;
    assign running = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_prog_counter.sv
// Bench for prog_counter (WIDTH=8, PRE_W=8): directed stimulus, a
// behavioural reference model compared on every cycle, and literal checks.
module tb_prog_counter;

  localparam int W = 8;
  localparam int P = 8;

  // ---------------- clock / reset ----------------
  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         clear;
  logic         load;
  logic [W-1:0] load_value;
  logic         enable;
  logic         up_down;
  logic [1:0]   mode;
  logic [W-1:0] limit;
  logic [P-1:0] prescale;
  logic [W-1:0] count;
  logic         tc;
  logic         wrapped;
  logic         running;
  logic         done;

  always #5 Clk = ~Clk;

  prog_counter #(.WIDTH(W), .PRE_W(P)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .enable     (enable),
    .up_down    (up_down),
    .mode       (mode),
    .limit      (limit),
    .prescale   (prescale),
    .count      (count),
    .tc         (tc),
    .wrapped    (wrapped),
    .running    (running),
    .done       (done)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_lit(input string name, input int c, input int t, input int w,
                         input int r, input int d);
    check({name, ".count"}, int'(count), c);
    check({name, ".tc"}, int'(tc), t);
    check({name, ".wrapped"}, int'(wrapped), w);
    check({name, ".running"}, int'(running), r);
    check({name, ".done"}, int'(done), d);
  endtask

  // ---------------- reference model ----------------
  // st: 0 idle, 1 run, 2 done
  typedef struct {
    int count;
    int pcnt;
    int st;
    bit tc;
    bit wrapped;
  } m_t;

  m_t m = '{count: 0, pcnt: 0, st: 0, tc: 1'b0, wrapped: 1'b0};

  function automatic m_t model_step(input m_t cur, input bit rst_n, input bit clr,
                                    input bit ld, input int lv, input bit en,
                                    input bit up, input int md, input int lim,
                                    input int pre);
    m_t nx;
    bit hit;
    nx = cur;
    nx.tc = 1'b0;
    if (!rst_n || clr) begin
      nx.count = 0; nx.pcnt = 0; nx.st = 0; nx.wrapped = 1'b0;
      return nx;
    end
    if (ld) begin
      nx.count = lv; nx.pcnt = 0;
      if (cur.st == 2) nx.st = 0;
      return nx;
    end
    if (cur.st == 0) begin
      if (en) nx.st = 1;
      return nx;
    end
    if (cur.st == 2) return nx;
    if (!en) nx.st = 0;
    if (cur.pcnt != pre) begin
      nx.pcnt = (cur.pcnt + 1) % (1 << P);
      return nx;
    end
    nx.pcnt = 0;
    hit = up ? (cur.count >= lim) : (cur.count == 0);
    if (!hit) begin
      nx.count = up ? (cur.count + 1) % (1 << W) : cur.count - 1;
      nx.tc = (md == 1) && (nx.count == (up ? lim : 0));
    end else if (md == 2) begin
      nx.tc = 1'b1; nx.st = 2;
    end else if (md != 1) begin
      nx.count = up ? 0 : lim;
      nx.tc = 1'b1; nx.wrapped = 1'b1;
    end
    return nx;
  endfunction

  always @(posedge Clk) begin
    m <= model_step(m, Reset_n, clear, load, int'(load_value), enable, up_down,
                    int'(mode), int'(limit), int'(prescale));
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge Clk) begin
    if (check_en) begin
      check("model.count", int'(count), m.count);
      check("model.tc", int'(tc), int'(m.tc));
      check("model.wrapped", int'(wrapped), int'(m.wrapped));
      check("model.running", int'(running), (m.st == 1) ? 1 : 0);
      check("model.done", int'(done), (m.st == 2) ? 1 : 0);
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(negedge Clk);
  endtask

  int exp_wrap[7] = '{1, 2, 3, 4, 5, 0, 1};
  int exp_pre[19] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 4, 4, 4};
  int exp_sat[6]  = '{3, 2, 1, 0, 0, 0};
  int exp_one[7]  = '{0, 1, 2, 3, 4, 4, 4};

  initial begin
    Reset_n = 1'b0; clear = 1'b0; load = 1'b1; load_value = 8'hAA; enable = 1'b1;
    up_down = 1'b1; mode = 2'b00; limit = '0; prescale = '0;
    step(); step();
    chk_lit("reset", 0, 0, 0, 0, 0);
    check_en = 1'b1;

    // WRAP up, limit 5
    Reset_n = 1'b1; load = 1'b0; enable = 1'b1; limit = 8'd5;
    step();
    chk_lit("wrap_start", 0, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) begin
      step();
      chk_lit("wrap_up", exp_wrap[i], (i == 5) ? 1 : 0, (i >= 5) ? 1 : 0, 1, 0);
    end
    clear = 1'b1; enable = 1'b0;
    step();
    clear = 1'b0;
    chk_lit("clear", 0, 0, 0, 0, 0);

    // Prescale 2 with a 4-cycle enable drop
    prescale = 8'd2; limit = 8'd255; enable = 1'b1;
    for (int j = 1; j <= 19; j++) begin
      step();
      check("presc.count", int'(count), exp_pre[j-1]);
      if (j == 9) enable = 1'b0;
      if (j == 13) enable = 1'b1;
    end
    enable = 1'b0;
    step();

    // SAT down from 3
    load = 1'b1; load_value = 8'd3; mode = 2'b01; up_down = 1'b0; limit = 8'd9;
    prescale = '0;
    step();
    load = 1'b0;
    chk_lit("sat_load", 3, 0, 0, 0, 0);
    enable = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step();
      chk_lit("sat_down", exp_sat[j], (j == 3) ? 1 : 0, 0, 1, 0);
    end
    enable = 1'b0;
    step();

    // ONESHOT up, limit 4
    load = 1'b1; load_value = 8'd0; mode = 2'b10; up_down = 1'b1; limit = 8'd4;
    step();
    load = 1'b0; enable = 1'b1;
    for (int j = 0; j < 7; j++) begin
      step();
      chk_lit("oneshot", exp_one[j], (j == 5) ? 1 : 0, 0, (j <= 4) ? 1 : 0, (j >= 5) ? 1 : 0);
    end
    enable = 1'b0; step(); step();
    enable = 1'b1; step(); step();
    chk_lit("oneshot_hold", 4, 0, 0, 0, 1);
    enable = 1'b0; load = 1'b1; load_value = 8'd0;
    step();
    load = 1'b0;
    chk_lit("oneshot_reload", 0, 0, 0, 0, 0);

    // clear beats load
    load = 1'b1; clear = 1'b1; load_value = 8'h77;
    step();
    load = 1'b0; clear = 1'b0;
    chk_lit("clear_load", 0, 0, 0, 0, 0);

    // load on a boundary tick wins, no tc
    mode = 2'b00; up_down = 1'b1; limit = 8'd2; enable = 1'b1;
    step(); step(); step();
    check("pre_load.count", int'(count), 2);
    load = 1'b1; load_value = 8'h50;
    step();
    load = 1'b0;
    chk_lit("load_tick", 8'h50, 0, 0, 1, 0);
    step();
    chk_lit("wrap_over", 0, 1, 1, 1, 0);

    // wrap at the top of the range
    limit = 8'd255; load = 1'b1; load_value = 8'd254;
    step();
    load = 1'b0;
    chk_lit("max_load", 254, 0, 1, 1, 0);
    step();
    chk_lit("max_top", 255, 0, 1, 1, 0);
    step();
    chk_lit("max_wrap", 0, 1, 1, 1, 0);

    // down WRAP using mode 11
    mode = 2'b11; up_down = 1'b0; limit = 8'd3; load = 1'b1; load_value = 8'd1;
    step();
    load = 1'b0;
    check("dwrap.load", int'(count), 1);
    step();
    chk_lit("dwrap_zero", 0, 0, 1, 1, 0);
    step();
    chk_lit("dwrap_reload", 3, 1, 1, 1, 0);
    step();
    chk_lit("dwrap_next", 2, 0, 1, 1, 0);

    // SAT up to limit 2
    mode = 2'b01; up_down = 1'b1; limit = 8'd2; load = 1'b1; load_value = 8'd0;
    step();
    load = 1'b0;
    step();
    chk_lit("sat_up1", 1, 0, 1, 1, 0);
    step();
    chk_lit("sat_up2", 2, 1, 1, 1, 0);
    step();
    chk_lit("sat_up_hold", 2, 0, 1, 1, 0);

    // reset mid-run overrides load
    Reset_n = 1'b0; load = 1'b1; load_value = 8'h33;
    step();
    chk_lit("reset_mid", 0, 0, 0, 0, 0);
    Reset_n = 1'b1; load = 1'b0; enable = 1'b0;
    step();
    chk_lit("after_reset", 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
